// File: rtl/hazard_fwd_ctrl.sv
// Forwarding select and load-use hazard control for the 5-stage pipeline.
// Tracks destination tags of the instructions in EX and MEM.
module hazard_fwd_ctrl #(
  parameter int XLEN_CNT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [4:0]          id_rs1,
  input  logic [4:0]          id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [4:0]          id_rd,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                flush,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                stall_pc,
  output logic                stall_ifid,
  output logic                bubble,
  output logic [XLEN_CNT-1:0] stall_cnt
);

  logic       ex_v;
  logic [4:0] ex_rd;
  logic       ex_rw;
  logic       ex_mr;
  logic       mem_v;
  logic [4:0] mem_rd;
  logic       mem_rw;

  logic       hazard;
  logic       kill;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  assign hazard = id_valid && ex_v && ex_mr && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)));

  assign kill = hazard || flush;

  // Nearer stage wins; x0 and unused sources never forward.
  always_comb begin
    sel_a = 2'b00;
    priority case (1'b1)
      (!id_use_rs1 || (id_rs1 == 5'd0)):
        sel_a = 2'b00;
      (ex_v && ex_rw && (ex_rd == id_rs1)):
        sel_a = 2'b10;
      (mem_v && mem_rw && (mem_rd == id_rs1)):
        sel_a = 2'b01;
      default:
        sel_a = 2'b00;
    endcase
  end

  always_comb begin
    sel_b = 2'b00;
    priority case (1'b1)
      (!id_use_rs2 || (id_rs2 == 5'd0)):
        sel_b = 2'b00;
      (ex_v && ex_rw && (ex_rd == id_rs2)):
        sel_b = 2'b10;
      (mem_v && mem_rw && (mem_rd == id_rs2)):
        sel_b = 2'b01;
      default:
        sel_b = 2'b00;
    endcase
  end

  // Flush takes precedence: squash without holding the front end.
  always_comb begin
    stall_pc   = 1'b0;
    stall_ifid = 1'b0;
    bubble     = 1'b0;
    if (!rst) begin
      if (flush) begin
        bubble = 1'b1;
      end else if (hazard) begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        bubble     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v      <= 1'b0;
      ex_rd     <= 5'd0;
      ex_rw     <= 1'b0;
      ex_mr     <= 1'b0;
      mem_v     <= 1'b0;
      mem_rd    <= 5'd0;
      mem_rw    <= 1'b0;
      fwd_a     <= 2'b00;
      fwd_b     <= 2'b00;
      stall_cnt <= '0;
    end else begin
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      mem_rw <= ex_rw;
      ex_v   <= id_valid && !kill;
      ex_rd  <= id_rd;
      ex_rw  <= id_reg_write;
      ex_mr  <= id_mem_read;
      fwd_a  <= kill ? 2'b00 : sel_a;
      fwd_b  <= kill ? 2'b00 : sel_b;
      if (hazard && !flush && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Testbench for hazard_fwd_ctrl: directed pipeline scenarios plus random
// instruction streams checked against an in-flight instruction queue model.
module tb_hazard_fwd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic        id_use_rs1 = 1'b0;
  logic        id_use_rs2 = 1'b0;
  logic [4:0]  id_rd = '0;
  logic        id_reg_write = 1'b0;
  logic        id_mem_read = 1'b0;
  logic        flush = 1'b0;

  logic [1:0]  fwd_a, fwd_b, fwd_a4, fwd_b4;
  logic        stall_pc, stall_ifid, bubble;
  logic        stall_pc4, stall_ifid4, bubble4;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt4;

  hazard_fwd_ctrl #(.XLEN_CNT(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .bubble(bubble), .stall_cnt(stall_cnt)
  );

  // Narrow counter instance so saturation is reachable in few cycles.
  hazard_fwd_ctrl #(.XLEN_CNT(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a(fwd_a4), .fwd_b(fwd_b4),
    .stall_pc(stall_pc4), .stall_ifid(stall_ifid4),
    .bubble(bubble4), .stall_cnt(stall_cnt4)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
  } instr_t;

  // inflight[0] is the instruction now in EX, inflight[1] the one in MEM.
  instr_t inflight[$];
  int     hz_total;
  int     exp_fa, exp_fb;
  int     n_assert = 0;
  int     n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_hazard();
    instr_t e;
    e = inflight[0];
    if (!id_valid || !e.v || !e.mr || e.rd == 0) return 0;
    return (id_use_rs1 && id_rs1 == e.rd) || (id_use_rs2 && id_rs2 == e.rd);
  endfunction

  function automatic int model_sel(input bit [4:0] rs, input bit use_rs);
    if (!use_rs || rs == 0) return 0;
    for (int i = 0; i < 2; i++)
      if (inflight[i].v && inflight[i].rw && inflight[i].rd == rs)
        return (i == 0) ? 2 : 1;
    return 0;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_clear();
    instr_t z;
    z = '{v: 0, rd: 0, rw: 0, mr: 0};
    inflight = {z, z};
    exp_fa = 0;
    exp_fb = 0;
    hz_total = 0;
  endtask

  // One clock: inputs already driven; check combinational outputs mid-cycle,
  // then advance the model across the edge and check registered outputs.
  task automatic step();
    bit     hz, sb, sp;
    instr_t n;
    hz = model_hazard();
    sp = !rst && !flush && hz;
    sb = !rst && (flush || hz);
    @(negedge clk);
    chk("stall_pc", stall_pc, sp);
    chk("stall_ifid", stall_ifid, sp);
    chk("bubble", bubble, sb);
    chk("stall_pc_w4", stall_pc4, sp);
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (hz && !flush) hz_total++;
      exp_fa = (hz || flush) ? 0 : model_sel(id_rs1, id_use_rs1);
      exp_fb = (hz || flush) ? 0 : model_sel(id_rs2, id_use_rs2);
      n = '{v: id_valid && !hz && !flush, rd: id_rd,
            rw: id_reg_write, mr: id_mem_read};
      inflight.push_front(n);
      void'(inflight.pop_back());
    end
    #1;
    chk("fwd_a", fwd_a, exp_fa);
    chk("fwd_b", fwd_b, exp_fb);
    chk("stall_cnt", stall_cnt, min_int(hz_total, 65535));
    chk("stall_cnt_w4", stall_cnt4, min_int(hz_total, 15));
  endtask

  task automatic issue(input bit v, input bit [4:0] rs1, input bit u1,
                       input bit [4:0] rs2, input bit u2, input bit [4:0] rd,
                       input bit rw, input bit mr, input bit fl, input bit r);
    id_valid = v;  id_rs1 = rs1; id_use_rs1 = u1;
    id_rs2 = rs2;  id_use_rs2 = u2; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; flush = fl; rst = r;
    step();
  endtask

  initial begin
    model_clear();
    rst = 1'b1;
    step();
    step();
    chk("reset_fwd_a", fwd_a, 0);
    chk("reset_cnt", stall_cnt, 0);

    // addi x5 ; add x6,x5,x5 -> both selects MEM ALU result
    issue(1, 0, 1, 0, 0, 5, 1, 0, 0, 0);
    issue(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
    chk("b2b_fwd_a", fwd_a, 2);
    chk("b2b_fwd_b", fwd_b, 2);

    // addi x5 ; nop ; sub x7,x5,x1
    issue(1, 0, 1, 0, 0, 5, 1, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 5, 1, 1, 1, 7, 1, 0, 0, 0);
    chk("dist2_fwd_a", fwd_a, 1);
    chk("dist2_fwd_b", fwd_b, 0);

    // lw x8 ; add x9,x8,x2 (stalled once, then re-evaluated)
    issue(1, 1, 1, 0, 0, 8, 1, 1, 0, 0);
    id_valid = 1; id_rs1 = 8; id_use_rs1 = 1; id_rs2 = 2; id_use_rs2 = 1;
    id_rd = 9; id_reg_write = 1; id_mem_read = 0;
    #2;
    chk("lu_stall_pc", stall_pc, 1);
    chk("lu_bubble", bubble, 1);
    issue(1, 8, 1, 2, 1, 9, 1, 0, 0, 0);
    chk("lu_cnt", stall_cnt, 1);
    issue(1, 8, 1, 2, 1, 9, 1, 0, 0, 0);
    chk("lu_fwd_a", fwd_a, 1);

    // lw x0 ; add x1,x0,x0 and lw x3 ; lui x3
    issue(1, 1, 1, 0, 0, 0, 1, 1, 0, 0);
    issue(1, 0, 1, 0, 1, 1, 1, 0, 0, 0);
    issue(1, 1, 1, 0, 0, 3, 1, 1, 0, 0);
    issue(1, 3, 0, 3, 0, 3, 1, 0, 0, 0);

    // flush together with a load-use hazard
    issue(1, 1, 1, 0, 0, 8, 1, 1, 0, 0);
    issue(1, 8, 1, 2, 1, 9, 1, 0, 1, 0);
    issue(1, 8, 1, 2, 1, 9, 1, 0, 0, 0);

    // reset during a load-use stall, then the first op never forwards
    issue(1, 1, 1, 0, 0, 8, 1, 1, 0, 0);
    issue(1, 8, 1, 2, 1, 9, 1, 0, 0, 1);
    issue(1, 8, 1, 8, 1, 9, 1, 0, 0, 0);
    chk("post_rst_fwd_a", fwd_a, 0);

    // repeated load-use to drive the narrow counter into saturation
    for (int i = 0; i < 20; i++) begin
      issue(1, 4, 1, 0, 0, 4, 1, 1, 0, 0);
      issue(1, 4, 1, 0, 0, 4, 1, 1, 0, 0);
    end
    chk("sat_w4", stall_cnt4, 15);

    // random streams over a small register window to provoke matches
    for (int i = 0; i < 3000; i++) begin
      issue(($urandom_range(0, 99) < 85),
            5'($urandom_range(0, 3)), 1'($urandom),
            5'($urandom_range(0, 3)), 1'($urandom),
            5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 8),
            ($urandom_range(0, 9) < 4), ($urandom_range(0, 99) < 8),
            ($urandom_range(0, 99) < 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
